// File: rtl/mem_access_unit.sv
// Memory access unit: a single-outstanding bus master that sequences controller reads and writes
// through IDLE/REQ/DONE and owns the IR/MDR. The bus timeout abort is enabled by MEM_TIMEOUT_EN.
module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              IRwrite,
   input  logic              lord,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] mdr,
   output logic              stall,
   output logic              error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              we_q, we_d;
   logic              ld_ir_q, ld_ir_d;
   logic              start_s;
   logic              abort_s;
   logic [DATA_W-1:0] sel_addr_s;

   assign start_s    = mem_read | mem_write;
   assign sel_addr_s = lord ? alu_out : pc;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] tcnt_q;
   logic             err_q;

   assign abort_s = (state_q == REQ) && !bus_ack && (tcnt_q == CNT_W'(TIMEOUT - 1));
   assign error   = err_q;

   // Cycles spent waiting in REQ, plus the sticky abort flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == REQ && !bus_ack) begin
            tcnt_q <= tcnt_q + CNT_W'(1);
         end else begin
            tcnt_q <= '0;
         end
         if (abort_s) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout_s;

   assign unused_timeout_s = (TIMEOUT > 0);
   assign abort_s          = 1'b0;
   assign error            = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         ir_q    <= '0;
         mdr_q   <= '0;
         we_q    <= 1'b0;
         ld_ir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         we_q    <= we_d;
         ld_ir_q <= ld_ir_d;
      end
   end

   // Next-state and register-load decisions
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      we_d    = we_q;
      ld_ir_d = ld_ir_q;
      case (state_q)
         IDLE: begin
            if (start_s) begin
               // Write wins over read, so a write never loads IR
               addr_d  = {sel_addr_s[DATA_W-1:2], 2'b00};
               wdata_d = wdata;
               we_d    = mem_write;
               ld_ir_d = IRwrite & ~mem_write;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (bus_ack) begin
               if (!we_q) begin
                  mdr_d = bus_rdata;
                  if (ld_ir_q) begin
                     ir_d = bus_rdata;
                  end else begin
                     ir_d = ir_q;
                  end
               end else begin
                  mdr_d = mdr_q;
               end
               state_d = DONE;
            end else if (abort_s) begin
               state_d = DONE;
            end else begin
               state_d = REQ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus_req   = (state_q == REQ);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign ir        = ir_q;
   assign mdr       = mdr_q;
   assign stall     = ((state_q == IDLE) && start_s) || (state_q == REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: fetch, store, write-wins, ack outside REQ,
// asynchronous reset mid-transaction and the timeout (or lack of it) on a missing ack.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, IRwrite, lord;
   logic [31:0] pc, alu_out, wdata;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [31:0] ir, mdr;
   logic        stall, error;

   int vectors     = 0;
   int miscompares = 0;
   int n;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .IRwrite(IRwrite),
      .lord(lord), .pc(pc), .alu_out(alu_out), .wdata(wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ir(ir), .mdr(mdr), .stall(stall), .error(error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; IRwrite = 1'b0; lord = 1'b0;
      pc = 32'h0; alu_out = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

      // Reset state
      cyc();
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_ir", ir, 32'h0);
      check("rst_mdr", mdr, 32'h0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;

      // Fetch: pc=0x10, ack on the third REQ cycle
      cyc();
      lord = 1'b0; pc = 32'h0000_0010; mem_read = 1'b1; IRwrite = 1'b1;
      smp();
      check("fetch_c0_stall", {31'd0, stall}, 32'd1);
      check("fetch_c0_req", {31'd0, bus_req}, 32'd0);
      cyc();
      smp();
      check("fetch_c1_req", {31'd0, bus_req}, 32'd1);
      check("fetch_c1_addr", bus_addr, 32'h0000_0010);
      check("fetch_c1_we", {31'd0, bus_we}, 32'd0);
      check("fetch_c1_stall", {31'd0, stall}, 32'd1);
      cyc();
      smp();
      check("fetch_c2_req", {31'd0, bus_req}, 32'd1);
      check("fetch_c2_stall", {31'd0, stall}, 32'd1);
      cyc();
      bus_ack = 1'b1; bus_rdata = 32'h8C22_0004;
      smp();
      check("fetch_c3_req", {31'd0, bus_req}, 32'd1);
      check("fetch_c3_ir_old", ir, 32'h0);
      cyc();
      bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
      smp();
      check("fetch_done_stall", {31'd0, stall}, 32'd0);
      check("fetch_done_req", {31'd0, bus_req}, 32'd0);
      check("fetch_ir", ir, 32'h8C22_0004);
      check("fetch_mdr", mdr, 32'h8C22_0004);
      // Request still held through DONE must not be reissued
      cyc();
      mem_read = 1'b0; IRwrite = 1'b0;
      smp();
      check("fetch_no_reissue_req", {31'd0, bus_req}, 32'd0);
      check("fetch_idle_stall", {31'd0, stall}, 32'd0);

      // Store: alu_out=0x107 -> word address 0x104; inputs change after capture
      cyc();
      lord = 1'b1; alu_out = 32'h0000_0107; wdata = 32'hDEAD_BEEF; mem_write = 1'b1;
      cyc();
      mem_write = 1'b0; alu_out = 32'h1111_1111; wdata = 32'h2222_2222;
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      smp();
      check("store_req", {31'd0, bus_req}, 32'd1);
      check("store_addr", bus_addr, 32'h0000_0104);
      check("store_we", {31'd0, bus_we}, 32'd1);
      check("store_wdata", bus_wdata, 32'hDEAD_BEEF);
      cyc();
      bus_ack = 1'b0;
      smp();
      check("store_done_stall", {31'd0, stall}, 32'd0);
      check("store_ir", ir, 32'h8C22_0004);
      check("store_mdr", mdr, 32'h8C22_0004);

      // Read and write together: write wins, no IR/MDR load
      cyc();
      cyc();
      lord = 1'b0; pc = 32'h0000_0022; wdata = 32'hCAFE_F00D;
      mem_read = 1'b1; mem_write = 1'b1; IRwrite = 1'b1;
      cyc();
      mem_read = 1'b0; mem_write = 1'b0; IRwrite = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
      smp();
      check("both_we", {31'd0, bus_we}, 32'd1);
      check("both_addr", bus_addr, 32'h0000_0020);
      check("both_wdata", bus_wdata, 32'hCAFE_F00D);
      cyc();
      bus_ack = 1'b0;
      smp();
      check("both_ir", ir, 32'h8C22_0004);
      check("both_mdr", mdr, 32'h8C22_0004);

      // Ack while idle is ignored
      cyc();
      cyc();
      bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      cyc();
      bus_ack = 1'b0;
      smp();
      check("stray_ack_mdr", mdr, 32'h8C22_0004);
      check("stray_ack_req", {31'd0, bus_req}, 32'd0);

      // Data read without IRwrite: MDR only
      cyc();
      lord = 1'b1; alu_out = 32'h0000_0203; mem_read = 1'b1;
      cyc();
      mem_read = 1'b0;
      smp();
      check("ld_addr", bus_addr, 32'h0000_0200);
      check("ld_we", {31'd0, bus_we}, 32'd0);
      cyc();
      bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
      cyc();
      bus_ack = 1'b0;
      smp();
      check("ld_mdr", mdr, 32'hA5A5_A5A5);
      check("ld_ir", ir, 32'h8C22_0004);

      // Asynchronous reset during REQ, then a late ack
      cyc();
      cyc();
      lord = 1'b0; pc = 32'h0000_0040; mem_read = 1'b1; IRwrite = 1'b1;
      cyc();
      mem_read = 1'b0; IRwrite = 1'b0;
      smp();
      check("arst_pre_req", {31'd0, bus_req}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_req_drop", {31'd0, bus_req}, 32'd0);
      check("arst_ir", ir, 32'h0);
      check("arst_mdr", mdr, 32'h0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      cyc();
      rst = 1'b0;
      smp();
      check("late_ack_mdr", mdr, 32'h0);
      check("late_ack_req", {31'd0, bus_req}, 32'd0);
      cyc();
      bus_ack = 1'b0;
      smp();
      check("late_ack_ir", ir, 32'h0);

      // Missing ack
      cyc();
      lord = 1'b0; pc = 32'h0000_0080; mem_read = 1'b1;
      cyc();
      mem_read = 1'b0;
      n = 0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 200; i++) begin
         smp();
         if (!bus_req) break;
         n++;
         cyc();
      end
      check("tmo_req_cycles", n, 32'd16);
      check("tmo_error", {31'd0, error}, 32'd1);
      check("tmo_mdr", mdr, 32'h0);
      cyc();
      cyc();
      smp();
      check("tmo_error_sticky", {31'd0, error}, 32'd1);
      check("tmo_idle_req", {31'd0, bus_req}, 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      smp();
      check("tmo_error_cleared", {31'd0, error}, 32'd0);
`else
      for (int i = 0; i < 120; i++) begin
         smp();
         if (bus_req) n++;
         cyc();
      end
      smp();
      check("no_tmo_req_cycles", n, 32'd120);
      check("no_tmo_req_still", {31'd0, bus_req}, 32'd1);
      check("no_tmo_error", {31'd0, error}, 32'd0);
      cyc();
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      cyc();
      bus_ack = 1'b0;
      smp();
      check("no_tmo_mdr", mdr, 32'h0BAD_F00D);
      check("no_tmo_done_stall", {31'd0, stall}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
